countdown_timer: RTL and testbench

//   Loadable WIDTH-bit down-counter with a valid/ready load handshake, pause, abort and auto-reload.
//   It complements the free-running up-counter: that counter measures elapsed cycles, and this block

---
 rtl/countdown_timer_pkg.sv | 11 +
 rtl/down_counter_core.sv | 25 ++
 rtl/countdown_timer.sv | 101 ++++++++++
 tb/tb_countdown_timer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared counter definitions: FSM state encodings and the default counter width,
// common to this timer and the free-running up-counter.
package countdown_timer_pkg;
  localparam int CNT_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/down_counter_core.sv
// WIDTH-bit down-count register with clear/load/decrement controls and an is_one flag.
module down_counter_core
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);
  // Decrement is gated on count>1 so the register can never wrap.
  always_ff @(posedge clk) begin
    if (!reset)                      count <= '0;
    else if (clear)                  count <= '0;
    else if (load)                   count <= load_value;
    else if (dec && count > WIDTH'(1)) count <= count - WIDTH'(1);
  end

  assign is_one = (count == WIDTH'(1));
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with valid/ready load, pause, abort and auto-reload;
// emits a one-cycle registered done pulse on expiry.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_en,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  state_e           state, state_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic [WIDTH-1:0] ld_val;
  logic             ld, dec, clr, done_n, is_one;

  assign load_ready = (state == ST_IDLE) && !abort;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      reload_q <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      reload_q <= reload_n;
      done     <= done_n;
    end
  end

  // Leaving HOLD with pause low counts as an ordinary run step, so each
  // paused cycle costs exactly one cycle of latency.
  always_comb begin
    state_n  = state;
    reload_n = reload_q;
    ld_val   = load_value;
    ld       = 1'b0;
    dec      = 1'b0;
    clr      = 1'b0;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid && load_ready) begin
          if (load_value != '0) begin
            ld       = 1'b1;
            reload_n = load_value;
            state_n  = ST_RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_RUN, ST_HOLD: begin
        if (abort) begin
          clr     = 1'b1;
          state_n = ST_IDLE;
        end else if (pause) begin
          state_n = ST_HOLD;
        end else begin
          state_n = ST_RUN;
          if (is_one) begin
            done_n = 1'b1;
            if (reload_en) begin
              ld     = 1'b1;
              ld_val = reload_q;
            end else begin
              clr     = 1'b1;
              state_n = ST_IDLE;
            end
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: begin
        clr     = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .clear      (clr),
    .load       (ld),
    .dec        (dec),
    .load_value (ld_val),
    .count      (count),
    .is_one     (is_one)
  );
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each stimulus step queues the expected
// post-edge outputs, and a monitor pops and compares them after every edge.
module tb_countdown_timer;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_value = '0;
  logic         reload_en = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } exp_t;
  exp_t sb[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .reload_en  (reload_en),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string tag, input logic lv, input logic [W-1:0] v,
                      input logic rl, input logic pa, input logic ab,
                      input logic [W-1:0] ec, input logic eb, input logic ed);
    exp_t e;
    load_valid = lv; load_value = v; reload_en = rl; pause = pa; abort = ab;
    e.tag = tag; e.c = ec; e.b = eb; e.d = ed;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".count"}, 32'(count), 32'(e.c));
      chk({e.tag, ".busy"},  32'(busy),  32'(e.b));
      chk({e.tag, ".done"},  32'(done),  32'(e.d));
    end
  end

  initial begin
    // 1: reset
    step("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.load_ready", 32'(load_ready), 1);

    // 2: one-shot of 5
    step("ld5", 1, 5, 0, 0, 0, 5, 1, 0);
    for (int i = 4; i >= 1; i--) step("run5", 0, 0, 0, 0, 0, W'(i), 1, 0);
    step("exp5", 0, 0, 0, 0, 0, 0, 0, 1);
    step("post5", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post5.load_ready", 32'(load_ready), 1);

    // 3: auto-reload of 3
    step("ld3", 1, 3, 1, 0, 0, 3, 1, 0);
    for (int i = 1; i <= 10; i++)
      step("rel3", 0, 0, 1, 0, 0, W'(3 - (i % 3)), 1, (i % 3) == 0);
    step("abort3", 0, 0, 1, 0, 1, 0, 0, 0);

    // 4: pause at count 2 for 3 cycles, done 7 cycles after load
    step("ld4", 1, 4, 0, 0, 0, 4, 1, 0);
    step("run4", 0, 0, 0, 0, 0, 3, 1, 0);
    step("run4", 0, 0, 0, 0, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) step("hold4", 0, 0, 0, 1, 0, 2, 1, 0);
    step("res4", 0, 0, 0, 0, 0, 1, 1, 0);
    step("exp4", 0, 0, 0, 0, 0, 0, 0, 1);
    //    pause exactly on the expiry cycle defers done
    step("ld2", 1, 2, 0, 0, 0, 2, 1, 0);
    step("run2", 0, 0, 0, 0, 0, 1, 1, 0);
    step("hold2", 0, 0, 0, 1, 0, 1, 1, 0);
    step("hold2", 0, 0, 0, 1, 0, 1, 1, 0);
    step("exp2", 0, 0, 0, 0, 0, 0, 0, 1);

    // 5: abort mid-run, then abort+load in IDLE is ignored
    step("ld6", 1, 6, 0, 0, 0, 6, 1, 0);
    for (int i = 5; i >= 3; i--) step("run6", 0, 0, 0, 0, 0, W'(i), 1, 0);
    step("abort6", 0, 0, 0, 0, 1, 0, 0, 0);
    abort = 1'b1; load_valid = 1'b1; load_value = 7;
    #1 chk("abt.load_ready", 32'(load_ready), 0);
    step("abtld", 1, 7, 0, 0, 1, 0, 0, 0);
    step("abtld2", 0, 0, 0, 0, 0, 0, 0, 0);

    // 6: zero-length load, then reset mid-run
    step("ld0", 1, 0, 0, 0, 0, 0, 0, 1);
    step("ld0b", 0, 0, 0, 0, 0, 0, 0, 0);
    step("ld8", 1, 8, 0, 0, 0, 8, 1, 0);
    step("run8", 0, 0, 0, 0, 0, 7, 1, 0);
    step("run8", 0, 0, 0, 0, 0, 6, 1, 0);
    reset = 1'b0;
    step("rst8", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("post8", 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk); #3;
    chk("sb.drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
